// File: rtl/imem_loader_pkg.sv
// Shared state encodings, framing constants and widths for the boot-time
// instruction memory loader.
package imem_loader_pkg;

   typedef logic [2:0] loader_state_t;

   localparam loader_state_t IDLE    = 3'd0;
   localparam loader_state_t HDR     = 3'd1;
   localparam loader_state_t PAYLOAD = 3'd2;
   localparam loader_state_t CHECK   = 3'd3;
   localparam loader_state_t DONE    = 3'd4;
   localparam loader_state_t ERROR   = 3'd5;

   localparam int unsigned HDR_BYTES  = 4;
   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned WORD_W     = 32;

   // States in which the loader owns the byte stream.
   function automatic logic is_busy(input loader_state_t s);
      return (s == HDR) || (s == PAYLOAD) || (s == CHECK);
   endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Little-endian byte-to-word packer; flags the byte that completes a word so
// the caller can act on the full word in the same cycle.
module byte_assembler
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              byte_en,
   input  logic [BYTE_W-1:0] byte_data,
   output logic [WORD_W-1:0] word_next_c,
   output logic              word_valid_c
);

   localparam int unsigned CNT_W = $clog2(WORD_BYTES);

   logic [CNT_W-1:0]  cnt;
   logic [WORD_W-1:0] word_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         word_q <= '0;
      end else if (clear) begin
         cnt    <= '0;
         word_q <= '0;
      end else if (byte_en) begin
         cnt    <= cnt + CNT_W'(1);
         word_q <= word_next_c;
      end
   end

   // Newest byte enters at the top so the first byte ends up in [7:0].
   assign word_next_c  = {byte_data, word_q[WORD_W-1:BYTE_W]};
   assign word_valid_c = byte_en && (cnt == CNT_W'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length/payload/checksum byte frame, writes the words
// into instruction memory and holds the core in reset until a clean load.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned depth_log2 = 10
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BYTE_W-1:0]     byte_data,
   input  logic                  byte_valid,
   output logic                  byte_ready,
   output logic                  imem_we,
   output logic [depth_log2-1:0] imem_addr,
   output logic [WORD_W-1:0]     imem_wdata,
   output logic                  core_rstn,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [depth_log2:0]   word_count
);

   localparam int unsigned CNT_W = depth_log2 + 1;
   localparam logic [WORD_W-1:0] MAX_WORDS = WORD_W'(1) << depth_log2;

   loader_state_t     state;
   loader_state_t     state_d;
   logic [CNT_W-1:0]  len_q;
   logic [BYTE_W-1:0] csum_q;

   logic              accept_c;
   logic              asm_en_c;
   logic              asm_clear_c;
   logic              len_bad_c;
   logic              last_word_c;
   logic              word_valid_c;
   logic [WORD_W-1:0] word_next_c;

   assign accept_c    = byte_valid && byte_ready;
   assign asm_en_c    = accept_c && ((state == HDR) || (state == PAYLOAD));
   assign asm_clear_c = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
   assign len_bad_c   = (word_next_c == '0) || (word_next_c > MAX_WORDS);
   assign last_word_c = (word_count + CNT_W'(1)) == len_q;

   byte_assembler u_asm (
      .clk          (clk),
      .rst          (rst),
      .clear        (asm_clear_c),
      .byte_en      (asm_en_c),
      .byte_data    (byte_data),
      .word_next_c  (word_next_c),
      .word_valid_c (word_valid_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE, DONE, ERROR: if (start) state_d = HDR;
         HDR:               if (word_valid_c) state_d = len_bad_c ? ERROR : PAYLOAD;
         PAYLOAD:           if (word_valid_c && last_word_c) state_d = CHECK;
         CHECK:             if (accept_c) state_d = (byte_data == csum_q) ? DONE : ERROR;
         default:           state_d = IDLE;
      endcase
   end

   // Status flags follow the next state so they line up with the state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_ready <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         core_rstn  <= 1'b0;
      end else begin
         byte_ready <= is_busy(state_d);
         busy       <= is_busy(state_d);
         done       <= (state_d == DONE);
         error      <= (state_d == ERROR);
         core_rstn  <= (state_d == DONE);
      end
   end

   // Length capture, checksum and the memory write port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q      <= '0;
         csum_q     <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         word_count <= '0;
      end else begin
         imem_we <= 1'b0;
         if (asm_clear_c) begin
            csum_q     <= '0;
            word_count <= '0;
         end
         if ((state == HDR) && word_valid_c) begin
            len_q <= word_next_c[CNT_W-1:0];
         end
         if ((state == PAYLOAD) && accept_c) begin
            csum_q <= csum_q ^ byte_data;
            if (word_valid_c) begin
               imem_we    <= 1'b1;
               imem_addr  <= word_count[depth_log2-1:0];
               imem_wdata <= word_next_c;
               word_count <= word_count + CNT_W'(1);
            end
         end
      end
   end

endmodule
